// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types, constants and helpers for the trace-driven cache model
package cache_pkg;

  typedef logic [15:0] u16;
  typedef logic [31:0] u32;
  typedef logic [63:0] u64;
  typedef real         float;
  typedef real         double;

  // Storage widths for one line; narrower tags/ages are zero-extended into them
  localparam int MAX_TAG_W = 32;
  localparam int MAX_AGE_W = 8;

  // Ceiling log2, usable in constant expressions
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [MAX_TAG_W-1:0] tag;
    logic [MAX_AGE_W-1:0] age;
  } line_t;

endpackage

// File: rtl/cache_lru.sv
// rtl/cache_lru.sv - per-set hit detection, victim choice and true-LRU age update
module cache_lru
  import cache_pkg::*;
#(
  parameter int ASSOC = 2,
  parameter int TAG_W = 32,
  parameter int AGE_W = 8,
  parameter int WAY_W = 1
) (
  input  logic [ASSOC-1:0]       valid_i,
  input  logic [ASSOC*TAG_W-1:0] tags_i,
  input  logic [ASSOC*AGE_W-1:0] ages_i,
  input  logic [TAG_W-1:0]       tag_i,
  output logic                   hit_o,
  output logic [WAY_W-1:0]       hit_way_o,
  output logic                   full_o,
  output logic [WAY_W-1:0]       victim_way_o,
  output logic [WAY_W-1:0]       access_way_o,
  output logic [ASSOC*AGE_W-1:0] ages_o
);

  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] lru_way;
  logic [AGE_W-1:0] lru_age;
  logic [AGE_W-1:0] acc_age;
  logic [AGE_W-1:0] cur_age;

  // Find the hit way, the lowest free way and the oldest way, then age the set around the accessed way
  always_comb begin
    hit_o        = 1'b0;
    hit_way_o    = '0;
    full_o       = 1'b1;
    free_way     = '0;
    lru_way      = '0;
    lru_age      = ages_i[AGE_W-1:0];
    acc_age      = '0;
    cur_age      = '0;
    ages_o       = ages_i;

    for (int w = 0; w < ASSOC; w++) begin
      if (!hit_o && valid_i[w] && (tags_i[w*TAG_W +: TAG_W] == tag_i)) begin
        hit_o     = 1'b1;
        hit_way_o = WAY_W'(w);
      end
    end

    // Scanning downward leaves the lowest-numbered invalid way selected
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        full_o   = 1'b0;
        free_way = WAY_W'(w);
      end
    end

    for (int w = 1; w < ASSOC; w++) begin
      if (ages_i[w*AGE_W +: AGE_W] > lru_age) begin
        lru_age = ages_i[w*AGE_W +: AGE_W];
        lru_way = WAY_W'(w);
      end
    end

    victim_way_o = full_o ? lru_way : free_way;
    access_way_o = hit_o ? hit_way_o : victim_way_o;

    for (int w = 0; w < ASSOC; w++) begin
      if (access_way_o == WAY_W'(w)) begin
        acc_age = ages_i[w*AGE_W +: AGE_W];
      end
    end

    // Ages stay a permutation: the touched way becomes 0, everything younger shifts back by one
    for (int w = 0; w < ASSOC; w++) begin
      cur_age = ages_i[w*AGE_W +: AGE_W];
      if (access_way_o == WAY_W'(w)) begin
        ages_o[w*AGE_W +: AGE_W] = '0;
      end else if (cur_age < acc_age) begin
        ages_o[w*AGE_W +: AGE_W] = cur_age + 1'b1;
      end else begin
        ages_o[w*AGE_W +: AGE_W] = cur_age;
      end
    end
  end

endmodule

// File: rtl/cache_sim.sv
// rtl/cache_sim.sv - set-associative tag-only cache acting as a trace-driven hit/miss counter
module cache_sim
  import cache_pkg::*;
#(
  parameter int SETS         = 16,
  parameter int ASSOC        = 2,
  parameter int LINESIZE     = 128,
  parameter int ADDRESS_SIZE = 16
) (
  input logic                    clk,
  input logic                    reset,
  input logic                    rw,
  input logic [ADDRESS_SIZE-1:0] address
);

  localparam int bsWidth    = clog2(LINESIZE);
  localparam int indexWidth = clog2(SETS);
  localparam int tagWidth   = ADDRESS_SIZE - bsWidth - indexWidth;
  localparam int WAY_W      = (clog2(ASSOC) < 1) ? 1 : clog2(ASSOC);

  logic [indexWidth-1:0] cache_index;
  logic [tagWidth-1:0]   cache_tag;
  logic                  offset_unused;

  assign cache_index   = address[bsWidth+indexWidth-1:bsWidth];
  assign cache_tag     = address[ADDRESS_SIZE-1:bsWidth+indexWidth];
  assign offset_unused = ^address[bsWidth-1:0];

  line_t lines_q [SETS][ASSOC];
  line_t set_d   [ASSOC];

  u32 accesses_q, accesses_d;
  u32 reads_q, reads_d;
  u32 writes_q, writes_d;
  u32 hits_q, hits_d;
  u32 misses_q, misses_d;
  u32 evictions_q, evictions_d;
  u32 writebacks_q, writebacks_d;

  u32 cAccesses, cReads, cWrites, cHits, cMisses, numEvictions, numWritebacks;
  double hitRatio, missRatio;

  assign cAccesses     = accesses_q;
  assign cReads        = reads_q;
  assign cWrites       = writes_q;
  assign cHits         = hits_q;
  assign cMisses       = misses_q;
  assign numEvictions  = evictions_q;
  assign numWritebacks = writebacks_q;

  logic [ASSOC-1:0]           set_valid;
  logic [ASSOC-1:0]           set_dirty;
  logic [ASSOC*MAX_TAG_W-1:0] set_tags;
  logic [ASSOC*MAX_AGE_W-1:0] set_ages;
  logic [ASSOC*MAX_AGE_W-1:0] next_ages;
  logic [MAX_TAG_W-1:0]       tag_ext;
  logic                       hit;
  logic                       full;
  logic [WAY_W-1:0]           hit_way;
  logic [WAY_W-1:0]           victim_way;
  logic [WAY_W-1:0]           access_way;
  logic                       victim_dirty;

  assign tag_ext = MAX_TAG_W'(cache_tag);

  // Flatten the indexed set so the LRU block sees one set at a time
  always_comb begin
    set_valid    = '0;
    set_dirty    = '0;
    set_tags     = '0;
    set_ages     = '0;
    for (int w = 0; w < ASSOC; w++) begin
      set_valid[w]                        = lines_q[cache_index][w].valid;
      set_dirty[w]                        = lines_q[cache_index][w].dirty;
      set_tags[w*MAX_TAG_W +: MAX_TAG_W]  = lines_q[cache_index][w].tag;
      set_ages[w*MAX_AGE_W +: MAX_AGE_W]  = lines_q[cache_index][w].age;
    end
  end

  cache_lru #(
    .ASSOC (ASSOC),
    .TAG_W (MAX_TAG_W),
    .AGE_W (MAX_AGE_W),
    .WAY_W (WAY_W)
  ) u_lru (
    .valid_i      (set_valid),
    .tags_i       (set_tags),
    .ages_i       (set_ages),
    .tag_i        (tag_ext),
    .hit_o        (hit),
    .hit_way_o    (hit_way),
    .full_o       (full),
    .victim_way_o (victim_way),
    .access_way_o (access_way),
    .ages_o       (next_ages)
  );

  // Next contents of the indexed set: new ages everywhere, fill or dirty-mark on the accessed way
  always_comb begin
    victim_dirty = 1'b0;
    for (int w = 0; w < ASSOC; w++) begin
      if (victim_way == WAY_W'(w)) begin
        victim_dirty = set_dirty[w];
      end
      set_d[w]     = lines_q[cache_index][w];
      set_d[w].age = next_ages[w*MAX_AGE_W +: MAX_AGE_W];
      if (access_way == WAY_W'(w)) begin
        set_d[w].valid = 1'b1;
        set_d[w].tag   = tag_ext;
        set_d[w].dirty = hit ? (set_d[w].dirty | rw) : rw;
      end
    end
  end

  // Statistics advance by one access; evictions and writebacks only on a miss into a full set
  always_comb begin
    accesses_d   = accesses_q + 32'd1;
    reads_d      = reads_q + {31'd0, ~rw};
    writes_d     = writes_q + {31'd0, rw};
    hits_d       = hits_q + {31'd0, hit};
    misses_d     = misses_q + {31'd0, ~hit};
    evictions_d  = evictions_q + {31'd0, ~hit & full};
    writebacks_d = writebacks_q + {31'd0, ~hit & full & victim_dirty};
  end

  // Reset clears all lines and counters; otherwise commit one access per edge
  always_ff @(posedge clk) begin
    if (reset) begin
      accesses_q   <= '0;
      reads_q      <= '0;
      writes_q     <= '0;
      hits_q       <= '0;
      misses_q     <= '0;
      evictions_q  <= '0;
      writebacks_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < ASSOC; w++) begin
          lines_q[s][w] <= '{valid: 1'b0, dirty: 1'b0, tag: '0, age: MAX_AGE_W'(w)};
        end
      end
    end else begin
      accesses_q   <= accesses_d;
      reads_q      <= reads_d;
      writes_q     <= writes_d;
      hits_q       <= hits_d;
      misses_q     <= misses_d;
      evictions_q  <= evictions_d;
      writebacks_q <= writebacks_d;
      for (int w = 0; w < ASSOC; w++) begin
        lines_q[cache_index][w] <= set_d[w];
      end
    end
  end

  // Percent ratios follow the counters; both read zero before any access
  always_comb begin
    hitRatio  = 0.0;
    missRatio = 0.0;
    if (accesses_q != '0) begin
      hitRatio  = 100.0 * real'(hits_q) / real'(accesses_q);
      missRatio = 100.0 * real'(misses_q) / real'(accesses_q);
    end
  end

endmodule

// File: tb/tb_cache_sim.sv
// tb/tb_cache_sim.sv - scoreboard bench for cache_sim with a timestamp-LRU reference model
module tb_cache_sim;
  localparam int SETS     = 16;
  localparam int ASSOC    = 2;
  localparam int LINESIZE = 128;
  localparam int AW       = 16;
  localparam int OFF_BITS = 7;
  localparam int IDX_BITS = 4;

  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic          rw      = 1'b0;
  logic [AW-1:0] address = '0;

  cache_sim #(
    .SETS         (SETS),
    .ASSOC        (ASSOC),
    .LINESIZE     (LINESIZE),
    .ADDRESS_SIZE (AW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rw      (rw),
    .address (address)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned acc, rd, wr, hits, misses, ev, wb, idx, tg;
  } exp_t;
  exp_t exp_q[$];

  bit          m_valid [SETS][ASSOC];
  bit          m_dirty [SETS][ASSOC];
  int unsigned m_tag   [SETS][ASSOC];
  longint      m_used  [SETS][ASSOC];
  longint      m_now;
  int unsigned m_acc, m_rd, m_wr, m_hits, m_misses, m_ev, m_wb;

  function automatic void model_reset();
    m_acc = 0; m_rd = 0; m_wr = 0; m_hits = 0; m_misses = 0; m_ev = 0; m_wb = 0;
    m_now = 0;
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < ASSOC; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = 0;
        m_used[s][w]  = -w;
      end
    end
  endfunction

  function automatic void model_access(input bit w, input int unsigned a);
    int unsigned s = (a >> OFF_BITS) % SETS;
    int unsigned t = a >> (OFF_BITS + IDX_BITS);
    int way = -1;
    m_acc++;
    if (w) m_wr++; else m_rd++;
    m_now++;
    for (int i = 0; i < ASSOC; i++)
      if (m_valid[s][i] && m_tag[s][i] == t) way = i;
    if (way >= 0) begin
      m_hits++;
      if (w) m_dirty[s][way] = 1'b1;
    end else begin
      m_misses++;
      for (int i = ASSOC - 1; i >= 0; i--)
        if (!m_valid[s][i]) way = i;
      if (way < 0) begin
        way = 0;
        for (int i = 1; i < ASSOC; i++)
          if (m_used[s][i] < m_used[s][way]) way = i;
        m_ev++;
        if (m_dirty[s][way]) m_wb++;
      end
      m_valid[s][way] = 1'b1;
      m_tag[s][way]   = t;
      m_dirty[s][way] = w;
    end
    m_used[s][way] = m_now;
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_real(input string name, input real act, input real req);
    n_checks++;
    if (act - req > 1e-6 || req - act > 1e-6) begin
      n_fail++;
      $display("FAIL %s: got %f expected %f (t=%0t)", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus: drive on the falling edge and queue the expected state after the next rising edge
  task automatic drive(input bit r, input bit w, input logic [AW-1:0] a);
    exp_t e;
    @(negedge clk);
    reset   = r;
    rw      = w;
    address = a;
    if (r) model_reset();
    else model_access(w, 32'(a));
    e.acc = m_acc; e.rd = m_rd; e.wr = m_wr; e.hits = m_hits; e.misses = m_misses;
    e.ev = m_ev; e.wb = m_wb;
    e.idx = (32'(a) >> OFF_BITS) % SETS;
    e.tg  = 32'(a) >> (OFF_BITS + IDX_BITS);
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: after each rising edge compare the DUT against the oldest queued expectation
  initial begin
    exp_t e;
    real  hr, mr;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cAccesses", dut.cAccesses, e.acc);
        chk("cReads", dut.cReads, e.rd);
        chk("cWrites", dut.cWrites, e.wr);
        chk("cHits", dut.cHits, e.hits);
        chk("cMisses", dut.cMisses, e.misses);
        chk("numEvictions", dut.numEvictions, e.ev);
        chk("numWritebacks", dut.numWritebacks, e.wb);
        chk("cache_index", dut.cache_index, e.idx);
        chk("cache_tag", dut.cache_tag, e.tg);
        hr = (e.acc == 0) ? 0.0 : 100.0 * real'(e.hits) / real'(e.acc);
        mr = (e.acc == 0) ? 0.0 : 100.0 * real'(e.misses) / real'(e.acc);
        chk_real("hitRatio", dut.hitRatio, hr);
        chk_real("missRatio", dut.missRatio, mr);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    bit            w;
    bit            r;
    model_reset();

    // Decode of 0xABCD while held in reset
    drive(1'b1, 1'b0, 16'hABCD);
    settle();
    chk("decode_index", dut.cache_index, 7);
    chk("decode_tag", dut.cache_tag, 32'h15);
    chk("reset_accesses", dut.cAccesses, 0);

    // Read miss then hit in the same line
    drive(1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 16'h007F);
    settle();
    chk("rd_pair_acc", dut.cAccesses, 2);
    chk("rd_pair_reads", dut.cReads, 2);
    chk("rd_pair_hits", dut.cHits, 1);
    chk("rd_pair_misses", dut.cMisses, 1);
    chk_real("rd_pair_ratio", dut.hitRatio, 50.0);

    // Three writes into set 0: one dirty eviction of tag 0
    drive(1'b1, 1'b0, 16'h0000);
    drive(1'b0, 1'b1, 16'h0000);
    drive(1'b0, 1'b1, 16'h0800);
    drive(1'b0, 1'b1, 16'h1000);
    settle();
    chk("wr3_misses", dut.cMisses, 3);
    chk("wr3_evictions", dut.numEvictions, 1);
    chk("wr3_writebacks", dut.numWritebacks, 1);
    drive(1'b0, 1'b0, 16'h0800);
    settle();
    chk("wr3_tag1_kept", dut.cHits, 1);

    // LRU ordering
    drive(1'b1, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 16'h0800);
    drive(1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 16'h1000);
    drive(1'b0, 1'b0, 16'h0800);
    settle();
    chk("lru_hits", dut.cHits, 1);
    chk("lru_misses", dut.cMisses, 4);
    chk("lru_evictions", dut.numEvictions, 2);
    chk("lru_writebacks", dut.numWritebacks, 0);

    // Independent sets
    drive(1'b1, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 16'h0080);
    settle();
    chk("sets_misses", dut.cMisses, 2);
    chk("sets_evictions", dut.numEvictions, 0);

    // Randomized trace concentrated on a few sets and tags, with occasional resets
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom % 150) == 0;
      w = 1'(($urandom % 2));
      if (($urandom % 8) == 0) a = AW'($urandom);
      else a = AW'(($urandom_range(0, 3) << 11) | ($urandom_range(0, 3) << 7) | $urandom_range(0, 127));
      drive(r, w, a);
    end

    // Reset in the middle of a trace drops cached lines
    drive(1'b0, 1'b1, 16'h1234);
    drive(1'b0, 1'b0, 16'h0000);
    drive(1'b1, 1'b0, 16'h0000);
    settle();
    chk("midrst_acc", dut.cAccesses, 0);
    chk("midrst_misses", dut.cMisses, 0);
    chk_real("midrst_hit_ratio", dut.hitRatio, 0.0);
    chk_real("midrst_miss_ratio", dut.missRatio, 0.0);
    drive(1'b0, 1'b0, 16'h0000);
    settle();
    chk("midrst_reread_miss", dut.cMisses, 1);
    chk("midrst_reread_hits", dut.cHits, 0);

    drive(1'b1, 1'b0, 16'h0000);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
